msp430_alu_wb: RTL

- Writeback stage directly downstream of the ALU in the MSP430 execution unit.
- Captures the ALU result and status at the end of an execution cycle.
- Performs one of two writes: a registered register-file write, or a byte-lane memory write with a ready handshake and a wait-state timeout.
- Owns the architectural status flags {V,N,Z,C} and stalls the frontend while a memory write is pending.

---
 rtl/msp430_alu_wb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/msp430_alu_wb.sv
// MSP430 execution-unit writeback: registers the ALU result into the register file
// or issues a byte-lane memory write with ready handshake and wait-state timeout.
module msp430_alu_wb #(
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        exec_done,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_stat,
    input  logic [3:0]  alu_stat_wr,
    input  logic        inst_bw,
    input  logic        dst_reg_wr,
    input  logic [3:0]  dst_reg,
    input  logic        dst_mem_wr,
    input  logic [15:0] dst_addr,
    input  logic        mem_ready,
    output logic        reg_wr_en,
    output logic [3:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic [1:0]  mem_wr_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_dout,
    output logic [3:0]  sr_flags,
    output logic        wb_busy,
    output logic        wb_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MEM_WR = 1'b1
    } wb_state_t;

    // Abort fires on the wait cycle that brings the counter up to TMO_MAX.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    wb_state_t        state_r;
    wb_state_t        state_s;
    logic [TMO_W-1:0] cnt_r;
    logic [TMO_W-1:0] cnt_s;
    logic             capture_s;
    logic             reg_wr_en_s;
    logic [3:0]       reg_wr_addr_s;
    logic [15:0]      reg_wr_data_s;
    logic [1:0]       mem_wr_be_s;
    logic [15:0]      mem_addr_s;
    logic [15:0]      mem_dout_s;
    logic [3:0]       sr_flags_s;
    logic             wb_busy_s;
    logic             wb_err_s;

    function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                               input logic [3:0] stat,
                                               input logic [3:0] wr);
        return (cur & ~wr) | (stat & wr);
    endfunction

    // Next-state and next-output logic for the writeback FSM.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        capture_s     = exec_done & ~wb_busy;
        reg_wr_en_s   = 1'b0;
        reg_wr_addr_s = reg_wr_addr;
        reg_wr_data_s = reg_wr_data;
        mem_wr_be_s   = mem_wr_be;
        mem_addr_s    = mem_addr;
        mem_dout_s    = mem_dout;
        sr_flags_s    = sr_flags;
        wb_busy_s     = wb_busy;
        wb_err_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    // A register write targeting R2 replaces the whole status word.
                    if (dst_reg_wr && !dst_mem_wr && (dst_reg == 4'd2)) begin
                        sr_flags_s = {alu_out[8], alu_out[2], alu_out[1], alu_out[0]};
                    end else begin
                        sr_flags_s = merge_flags(sr_flags, alu_stat, alu_stat_wr);
                    end

                    if (dst_mem_wr) begin
                        state_s   = MEM_WR;
                        wb_busy_s = 1'b1;
                        cnt_s     = {TMO_W{1'b0}};
                        if (inst_bw) begin
                            mem_addr_s  = dst_addr;
                            mem_dout_s  = {alu_out[7:0], alu_out[7:0]};
                            mem_wr_be_s = dst_addr[0] ? 2'b10 : 2'b01;
                        end else begin
                            mem_addr_s  = {dst_addr[15:1], 1'b0};
                            mem_dout_s  = alu_out;
                            mem_wr_be_s = 2'b11;
                        end
                    end else if (dst_reg_wr) begin
                        reg_wr_en_s   = 1'b1;
                        reg_wr_addr_s = dst_reg;
                        reg_wr_data_s = inst_bw ? {8'h00, alu_out[7:0]} : alu_out;
                    end else begin
                        reg_wr_en_s = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_s     = IDLE;
                    mem_wr_be_s = 2'b00;
                    wb_busy_s   = 1'b0;
                    cnt_s       = {TMO_W{1'b0}};
                end else if (cnt_r == TMO_LAST) begin
                    state_s     = IDLE;
                    mem_wr_be_s = 2'b00;
                    wb_busy_s   = 1'b0;
                    wb_err_s    = 1'b1;
                    cnt_s       = {TMO_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + TMO_W'(1);
                end
            end
            default: begin
                state_s     = IDLE;
                mem_wr_be_s = 2'b00;
                wb_busy_s   = 1'b0;
                cnt_s       = {TMO_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {TMO_W{1'b0}};
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 4'h0;
            reg_wr_data <= 16'h0000;
            mem_wr_be   <= 2'b00;
            mem_addr    <= 16'h0000;
            mem_dout    <= 16'h0000;
            sr_flags    <= 4'h0;
            wb_busy     <= 1'b0;
            wb_err      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            reg_wr_en   <= reg_wr_en_s;
            reg_wr_addr <= reg_wr_addr_s;
            reg_wr_data <= reg_wr_data_s;
            mem_wr_be   <= mem_wr_be_s;
            mem_addr    <= mem_addr_s;
            mem_dout    <= mem_dout_s;
            sr_flags    <= sr_flags_s;
            wb_busy     <= wb_busy_s;
            wb_err      <= wb_err_s;
        end
    end

endmodule
